// File: rtl/sa_in_skew_feeder.sv
// Systolic-array input stage: vector FIFO feeding a diagonal skew.
// Lane r is delayed r extra cycles; fill/drain are zero-padded.
module sa_in_skew_feeder #(
    parameter int ROWS  = 8,
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ROWS*DW-1:0] in_a,
    input  logic [ROWS*DW-1:0] in_w,
    input  logic               in_last,
    input  logic               hold,
    output logic [ROWS*DW-1:0] out_a,
    output logic [ROWS*DW-1:0] out_w,
    output logic [ROWS-1:0]    out_vmask,
    output logic               fire,
    output logic               tile_done,
    output logic               underrun
);

    localparam int VW = ROWS * DW;
    localparam int EW = 2 * VW + 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (ROWS > 1) ? $clog2(ROWS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN
    } state_t;

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_drain_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_underrun;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_und_set;
    logic [EW-1:0] w_rd;
    logic          w_rd_last;
    logic [VW-1:0] w_rd_a;
    logic [VW-1:0] w_rd_w;

    // Flags come from the registered count only, never from the pop.
    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign in_ready  = !w_full;
    assign w_push    = in_valid && !w_full;

    assign w_rd      = r_mem[r_rptr];
    assign w_rd_last = w_rd[EW-1];
    assign w_rd_w    = w_rd[EW-2:VW];
    assign w_rd_a    = w_rd[VW-1:0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_last, in_w, in_a};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_drain_cnt;
        w_pop       = 1'b0;
        w_und_set   = 1'b0;
        if (!hold) begin
            unique case (r_state)
                S_IDLE, S_STREAM: begin
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_rd_last) begin
                            w_state_nxt = S_DRAIN;
                            w_cnt_nxt   = CW'(ROWS - 1);
                        end else begin
                            w_state_nxt = S_STREAM;
                        end
                    end else if (r_state == S_STREAM) begin
                        w_und_set = 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (r_drain_cnt == '0) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_cnt_nxt = r_drain_cnt - CW'(1);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_drain_cnt <= '0;
            r_underrun  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_cnt_nxt;
            r_underrun  <= r_underrun | w_und_set;
        end
    end

    // DRAIN at count zero coincides with the last lane's final element.
    assign tile_done = (r_state == S_DRAIN) && (r_drain_cnt == '0);
    assign underrun  = r_underrun;
    assign fire      = |out_vmask;

    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DW-1:0] r_a [r+1];
        logic [DW-1:0] r_w [r+1];
        logic [r:0]    r_v;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int s = 0; s <= r; s++) begin
                    r_a[s] <= '0;
                    r_w[s] <= '0;
                end
                r_v <= '0;
            end else if (!hold) begin
                r_a[0] <= w_pop ? w_rd_a[r*DW +: DW] : '0;
                r_w[0] <= w_pop ? w_rd_w[r*DW +: DW] : '0;
                r_v[0] <= w_pop;
                for (int s = 1; s <= r; s++) begin
                    r_a[s] <= r_a[s-1];
                    r_w[s] <= r_w[s-1];
                    r_v[s] <= r_v[s-1];
                end
            end
        end

        assign out_a[r*DW +: DW] = r_a[r];
        assign out_w[r*DW +: DW] = r_w[r];
        assign out_vmask[r]      = r_v[r];
    end

endmodule

// File: tb/tb_sa_in_skew_feeder.sv
// Bench for sa_in_skew_feeder: per-lane scoreboard plus
// directed timing checks on skew, fill, underrun, hold and reset.
module tb_sa_in_skew_feeder;

    localparam int ROWS  = 8;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int VW    = ROWS * DW;

    logic          clk;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [VW-1:0] in_a;
    logic [VW-1:0] in_w;
    logic          in_last;
    logic          hold;
    logic [VW-1:0] out_a;
    logic [VW-1:0] out_w;
    logic [ROWS-1:0] out_vmask;
    logic          fire;
    logic          tile_done;
    logic          underrun;

    sa_in_skew_feeder #(
        .ROWS (ROWS),
        .DW   (DW),
        .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_w     (in_w),
        .in_last  (in_last),
        .hold     (hold),
        .out_a    (out_a),
        .out_w    (out_w),
        .out_vmask(out_vmask),
        .fire     (fire),
        .tile_done(tile_done),
        .underrun (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    bit edge_hold = 1'b0;

    logic [2*DW-1:0] q_lane [ROWS][$];
    int q_tile[$];
    int tile_len  = 0;
    int cons_last = 0;

    int first_c [ROWS];
    int last_c  [ROWS];
    bit seen    [ROWS];
    int fire_cnt, done_cnt, done_raw, done_cyc;
    int v0q[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] mk(input int base);
        logic [VW-1:0] v;
        for (int r = 0; r < ROWS; r++) v[r*DW +: DW] = DW'(base + r);
        return v;
    endfunction

    task automatic clear_stats();
        for (int r = 0; r < ROWS; r++) begin
            seen[r]    = 1'b0;
            first_c[r] = 0;
            last_c[r]  = 0;
        end
        fire_cnt = 0;
        done_cnt = 0;
        done_raw = 0;
        done_cyc = 0;
        v0q.delete();
    endtask

    task automatic clear_sb();
        for (int r = 0; r < ROWS; r++) q_lane[r].delete();
        q_tile.delete();
        tile_len  = 0;
        cons_last = 0;
    endtask

    // Called at a negedge; returns at the negedge after the write edge.
    task automatic push_vec(input logic [VW-1:0] a, input logic [VW-1:0] w,
                            input logic last);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_w     = w;
        in_last  = last;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("push_timeout", 0, 1);
        end else begin
            for (int r = 0; r < ROWS; r++)
                q_lane[r].push_back({a[r*DW +: DW], w[r*DW +: DW]});
            tile_len++;
            if (last) begin
                q_tile.push_back(tile_len);
                tile_len = 0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int n, input int max_cyc);
        int k;
        k = 0;
        while (done_cnt < n && k < max_cyc) begin
            @(negedge clk);
            k++;
        end
        check("wait_done", done_cnt, n);
    endtask

    always @(posedge clk) begin
        cyc++;
        edge_hold = hold;
    end

    always @(negedge clk) begin : mon
        logic [DW-1:0] zor;
        if (rstn) begin
            zor = '0;
            for (int r = 0; r < ROWS; r++) begin
                if (out_vmask[r]) begin
                    if (!seen[r]) begin
                        seen[r]    = 1'b1;
                        first_c[r] = cyc;
                    end
                    last_c[r] = cyc;
                    if (!edge_hold) begin
                        if (r == 0) v0q.push_back(cyc);
                        if (q_lane[r].size() == 0)
                            check($sformatf("lane%0d_spurious", r), 1, 0);
                        else
                            check($sformatf("lane%0d_data", r),
                                  {out_a[r*DW +: DW], out_w[r*DW +: DW]},
                                  q_lane[r].pop_front());
                        if (r == ROWS-1) cons_last++;
                    end
                end else begin
                    zor = zor | out_a[r*DW +: DW] | out_w[r*DW +: DW];
                end
            end
            check("zero_pad", zor, 0);
            check("fire_or", fire, |out_vmask);
            if (fire) fire_cnt++;
            if (tile_done) begin
                done_raw++;
                if (!edge_hold) begin
                    done_cnt++;
                    done_cyc = cyc;
                    if (q_tile.size() == 0)
                        check("done_spurious", 1, 0);
                    else
                        check("tile_len", cons_last, q_tile.pop_front());
                    cons_last = 0;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int l0;
        int k;
        int len;
        logic [VW-1:0] snap_a, snap_w;
        logic [ROWS+1:0] snap_m;

        rstn     = 1'b0;
        hold     = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_w     = '0;
        in_last  = 1'b0;
        clear_stats();
        clear_sb();
        repeat (3) @(negedge clk);
        check("rst_ready", in_ready, 1);
        check("rst_out_a", out_a, 0);
        check("rst_out_w", out_w, 0);
        check("rst_flags", {out_vmask, fire, tile_done, underrun}, 0);
        rstn = 1'b1;
        @(negedge clk);

        // Basic 4-vector tile
        clear_stats();
        for (int i = 0; i < 4; i++)
            push_vec(mk(16*i), ~mk(16*i), i == 3);
        wait_done(1, 60);
        repeat (2) @(negedge clk);
        for (int r = 0; r < ROWS; r++) begin
            check($sformatf("t1_first%0d", r), first_c[r] - first_c[0], r);
            check($sformatf("t1_len%0d", r), last_c[r] - first_c[r], 3);
        end
        check("t1_fire_cnt", fire_cnt, 3 + ROWS);
        check("t1_done_cyc", done_cyc - first_c[0], ROWS + 2);
        check("t1_done_raw", done_raw, 1);
        check("t1_underrun", underrun, 0);

        // Fill the FIFO under hold
        clear_stats();
        hold = 1'b1;
        for (int i = 0; i < DEPTH; i++)
            push_vec(mk(8*i + 1), mk(3*i + 100), i == DEPTH-1);
        check("t2_full", in_ready, 0);
        in_valid = 1'b1;
        in_a     = mk(8'hE0);
        in_w     = mk(8'hF0);
        repeat (3) @(negedge clk);
        check("t2_no_accept", in_ready, 0);
        check("t2_hold_quiet", out_vmask, 0);
        in_valid = 1'b0;
        hold     = 1'b0;
        check("t2_ready_pop", in_ready, 0);
        @(negedge clk);
        check("t2_ready_back", in_ready, 1);
        wait_done(1, 100);
        repeat (2) @(negedge clk);
        check("t2_underrun", underrun, 0);

        // Underrun: 3-cycle gap on lane 0
        clear_stats();
        push_vec(mk(8'h40), mk(8'h50), 1'b0);
        push_vec(mk(8'h48), mk(8'h58), 1'b0);
        repeat (3) @(negedge clk);
        push_vec(mk(8'h60), mk(8'h70), 1'b1);
        wait_done(1, 60);
        repeat (2) @(negedge clk);
        check("t3_v0_cnt", v0q.size(), 3);
        if (v0q.size() == 3) begin
            check("t3_adjacent", v0q[1] - v0q[0], 1);
            check("t3_gap", v0q[2] - v0q[1], 4);
        end
        check("t3_underrun", underrun, 1);
        check("t3_done_raw", done_raw, 1);

        // Hold for 5 cycles in the middle of DRAIN
        clear_stats();
        push_vec(mk(8'h80), mk(8'h88), 1'b0);
        push_vec(mk(8'h90), mk(8'h98), 1'b0);
        push_vec(mk(8'hA0), mk(8'hA8), 1'b1);
        k = 0;
        while (!(out_vmask[0] && out_a[DW-1:0] == 8'hA0) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("t4_last_seen", k < 20, 1);
        l0 = cyc;
        repeat (2) @(negedge clk);
        hold   = 1'b1;
        snap_a = out_a;
        snap_w = out_w;
        snap_m = {out_vmask, fire, tile_done};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_frz_a", out_a, snap_a);
            check("t4_frz_w", out_w, snap_w);
            check("t4_frz_m", {out_vmask, fire, tile_done}, snap_m);
        end
        hold = 1'b0;
        wait_done(1, 40);
        repeat (2) @(negedge clk);
        check("t4_done_cyc", done_cyc - l0, ROWS - 1 + 5);
        check("t4_done_raw", done_raw, 1);

        // Asynchronous reset mid-STREAM with 6 entries queued
        clear_stats();
        push_vec(mk(8'h11), mk(8'h22), 1'b0);
        push_vec(mk(8'h33), mk(8'h44), 1'b0);
        hold = 1'b1;
        for (int i = 0; i < 5; i++)
            push_vec(mk(8'h55 + i), mk(8'h66 + i), 1'b0);
        check("t5_pre_active", out_vmask != 0, 1);
        #2;
        rstn = 1'b0;
        #1;
        check("t5_rst_a", out_a, 0);
        check("t5_rst_w", out_w, 0);
        check("t5_rst_flags", {out_vmask, fire, tile_done, underrun}, 0);
        check("t5_rst_ready", in_ready, 1);
        clear_sb();
        @(negedge clk);
        rstn = 1'b1;
        hold = 1'b0;
        clear_stats();
        repeat (30) @(negedge clk);
        check("t5_no_replay", fire_cnt, 0);
        check("t5_ready", in_ready, 1);
        check("t5_underrun", underrun, 0);
        check("t5_no_done", done_cnt, 0);

        // Single-vector tile
        clear_stats();
        push_vec(mk(8'hC0), mk(8'hD0), 1'b1);
        wait_done(1, 40);
        repeat (2) @(negedge clk);
        for (int r = 0; r < ROWS; r++) begin
            check($sformatf("t6_width%0d", r), last_c[r] - first_c[r], 0);
            check($sformatf("t6_diag%0d", r), first_c[r] - first_c[0], r);
        end
        check("t6_done_cyc", done_cyc - first_c[0], ROWS - 1);
        check("t6_fire_cnt", fire_cnt, ROWS);

        // Back-to-back random tiles
        clear_stats();
        for (int t = 0; t < 3; t++) begin
            len = $urandom_range(1, 5);
            for (int i = 0; i < len; i++)
                push_vec({$urandom(), $urandom()}, {$urandom(), $urandom()},
                         i == len - 1);
        end
        wait_done(3, 200);
        repeat (4) @(negedge clk);
        k = q_tile.size();
        for (int r = 0; r < ROWS; r++) k += q_lane[r].size();
        check("t7_sb_empty", k, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
